// File: rtl/booth_pkg.sv
// +---------------------------------------------------------------------------+
// | booth_pkg : state encoding, Booth pair codes and default sizing for the   |
// |             radix-2 Booth multiplier controller.                          |
// | Revision  : 1.0                                                           |
// +---------------------------------------------------------------------------+
`default_nettype none

package booth_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 5;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_M = 3'd1,
    S_LOAD_Q = 3'd2,
    S_EVAL   = 3'd3,
    S_ADD    = 3'd4,
    S_SUB    = 3'd5,
    S_SHIFT  = 3'd6,
    S_DONE   = 3'd7
  } state_e;

  // {Q[0], Q[-1]} pairs that require an ALU operation; other pairs just shift.
  localparam logic [1:0] PAIR_ADD = 2'b01;
  localparam logic [1:0] PAIR_SUB = 2'b10;

endpackage

`default_nettype wire

// File: rtl/booth_ctrl_if.sv
// +---------------------------------------------------------------------------+
// | booth_ctrl_if : strobe/status bundle between the Booth controller (slave) |
// |                 and the multiplier datapath (master).                     |
// | Revision      : 1.0                                                       |
// +---------------------------------------------------------------------------+
`default_nettype none

interface booth_ctrl_if;
  logic start;
  logic q0;
  logic qm1;
  logic ldA;
  logic clrA;
  logic sftA;
  logic ldQ;
  logic clrQ;
  logic sftQ;
  logic ldM;
  logic clrff;
  logic addsub;
  logic busy;
  logic done;

  modport master (
    output start, q0, qm1,
    input  ldA, clrA, sftA, ldQ, clrQ, sftQ, ldM, clrff, addsub, busy, done
  );

  modport slave (
    input  start, q0, qm1,
    output ldA, clrA, sftA, ldQ, clrQ, sftQ, ldM, clrff, addsub, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/booth_iter_cnt.sv
// +---------------------------------------------------------------------------+
// | booth_iter_cnt : Booth iteration counter; loads WIDTH, decrements to 0,   |
// |                  flags the final iteration.                               |
// | Revision       : 1.0                                                      |
// +---------------------------------------------------------------------------+
`default_nettype none

module booth_iter_cnt #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic clr_i,
  input  wire logic load_i,
  input  wire logic dec_i,
  output logic      cnt_is_one_o
);

  localparam logic [CNT_W-1:0] C_LOAD_VAL = CNT_W'(WIDTH);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Decrement is gated at zero so the counter can never wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (load_i)
      cnt_d = C_LOAD_VAL;
    else if (dec_i && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt_is_one_o = (cnt_q == CNT_W'(1));

endmodule

`default_nettype wire

// File: rtl/booth_ctrl.sv
// +---------------------------------------------------------------------------+
// | booth_ctrl : Moore FSM sequencing a radix-2 Booth multiplier datapath.    |
// |              Optional abort input enabled by BOOTH_CTRL_ABORT_EN.         |
// | Revision   : 1.0                                                          |
// +---------------------------------------------------------------------------+
`default_nettype none

module booth_ctrl
  import booth_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
`ifdef BOOTH_CTRL_ABORT_EN
  input  wire logic     abort,
`endif
  booth_ctrl_if.slave   bus
);

  state_e state_q;
  state_e state_d;

  logic cnt_load;
  logic cnt_dec;
  logic cnt_clr;
  logic cnt_is_one;
  logic abort_w;

`ifdef BOOTH_CTRL_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  booth_iter_cnt #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter_cnt (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (cnt_clr),
    .load_i       (cnt_load),
    .dec_i        (cnt_dec),
    .cnt_is_one_o (cnt_is_one)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_clr  = 1'b0;
    case (state_q)
      S_IDLE:   if (bus.start) state_d = S_LOAD_M;
      S_LOAD_M: begin
        cnt_load = 1'b1;
        state_d  = S_LOAD_Q;
      end
      S_LOAD_Q: state_d = S_EVAL;
      S_EVAL: begin
        case ({bus.q0, bus.qm1})
          PAIR_ADD: state_d = S_ADD;
          PAIR_SUB: state_d = S_SUB;
          default:  state_d = S_SHIFT;
        endcase
      end
      S_ADD:    state_d = S_SHIFT;
      S_SUB:    state_d = S_SHIFT;
      S_SHIFT: begin
        cnt_dec = 1'b1;
        state_d = cnt_is_one ? S_DONE : S_EVAL;
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    // Abort overrides every transition out of a non-idle state.
    if (abort_w && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      cnt_clr  = 1'b1;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
    end
  end

  assign bus.ldA    = (state_q == S_ADD) || (state_q == S_SUB);
  assign bus.addsub = (state_q == S_ADD);
  assign bus.clrA   = (state_q == S_LOAD_M);
  assign bus.ldM    = (state_q == S_LOAD_M);
  assign bus.clrff  = (state_q == S_LOAD_M);
  assign bus.ldQ    = (state_q == S_LOAD_Q);
  assign bus.clrQ   = 1'b0;
  assign bus.sftA   = (state_q == S_SHIFT);
  assign bus.sftQ   = (state_q == S_SHIFT);
  assign bus.done   = (state_q == S_DONE);
  assign bus.busy   = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_booth_ctrl.sv
// +---------------------------------------------------------------------------+
// | tb_booth_ctrl : directed self-checking bench for booth_ctrl with an       |
// |                 attached behavioural A/Q/M datapath.                      |
// | Revision      : 1.0                                                       |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_booth_ctrl;

  logic clk;
  logic rst_n;
  logic abort;
  int   checks;
  int   failures;

  logic [15:0] bus_m;
  logic [15:0] bus_q;
  logic [15:0] dp_a;
  logic [15:0] dp_mq;
  logic [15:0] dp_mm;
  logic        dp_qm1;

  booth_ctrl_if bus ();

  booth_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef BOOTH_CTRL_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model driven only by the controller strobes.
  always @(posedge clk) begin
    if (bus.ldM)   dp_mm  <= bus_m;
    if (bus.clrA)  dp_a   <= '0;
    if (bus.clrff) dp_qm1 <= 1'b0;
    if (bus.ldQ)   dp_mq  <= bus_q;
    if (bus.ldA)   dp_a   <= bus.addsub ? dp_a + dp_mm : dp_a - dp_mm;
    if (bus.sftA && bus.sftQ) begin
      dp_a   <= {dp_a[15], dp_a[15:1]};
      dp_mq  <= {dp_a[0], dp_mq[15:1]};
      dp_qm1 <= dp_mq[0];
    end
  end

  assign bus.q0  = dp_mq[0];
  assign bus.qm1 = dp_qm1;

  function automatic logic [10:0] outs();
    return {bus.ldA, bus.clrA, bus.sftA, bus.ldQ, bus.clrQ, bus.sftQ,
            bus.ldM, bus.clrff, bus.addsub, bus.busy, bus.done};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full multiplication; cycle numbers count edges from the start-sampling edge.
  task automatic run_op(input string tag, input logic [15:0] m, input logic [15:0] q,
                        input int exp_done, input int exp_narith, input logic [31:0] exp_prod);
    int cyc;
    int done_cyc;
    int n_lda;
    int n_sft;
    int n_clrq;
    bus_m     = m;
    bus_q     = q;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cyc       = 1;
    done_cyc  = -1;
    n_lda     = 0;
    n_sft     = 0;
    n_clrq    = 0;
    chk({tag, "_loadm_outs"}, 32'(outs()), 32'b010_0001_1010);
    while ((done_cyc < 0) && (cyc < 200)) begin
      if (bus.ldA)  n_lda++;
      if (bus.sftA) n_sft++;
      if (bus.clrQ) n_clrq++;
      if (bus.done) done_cyc = cyc;
      else begin
        tick();
        cyc++;
      end
    end
    chk({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_done));
    chk({tag, "_n_arith"},    32'(n_lda),    32'(exp_narith));
    chk({tag, "_n_shift"},    32'(n_sft),    32'd16);
    chk({tag, "_clrQ"},       32'(n_clrq),   32'd0);
    chk({tag, "_product"},    {dp_a, dp_mq}, exp_prod);
    tick();
    chk({tag, "_idle_after"}, 32'(outs()),   32'd0);
  endtask

  initial begin
    int cyc;
    int n_done;
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    abort     = 1'b0;
    bus.start = 1'b0;
    bus_m     = '0;
    bus_q     = '0;
    #12;
    chk("reset_outs", 32'(outs()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle_outs", 32'(outs()), 32'd0);

    run_op("t2_q0",     16'd3,      16'h0000, 35, 0,  32'h0000_0000);
    run_op("t3_q1",     16'd3,      16'h0001, 37, 2,  32'h0000_0003);
    run_op("t4_neg",    16'hFFFD,   16'h8000, 36, 1,  32'h0001_8000);
    run_op("v_qneg1",   16'd5,      16'hFFFF, 36, 1,  32'hFFFF_FFFB);
    run_op("v_alt",     16'd7,      16'h5555, 51, 16, 32'h0002_5553);

    // Start held high through the whole operation, including the DONE cycle.
    bus_m     = 16'd3;
    bus_q     = 16'h0000;
    bus.start = 1'b1;
    tick();
    cyc    = 1;
    n_done = 0;
    while (!bus.done && (cyc < 200)) begin
      tick();
      cyc++;
    end
    if (bus.done) n_done++;
    chk("t5_done_cycle", 32'(cyc), 32'd35);
    tick();
    chk("t5_idle_after_done", 32'(bus.busy), 32'd0);
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.done) n_done++;
    end
    chk("t5_done_count", 32'(n_done), 32'd1);
    chk("t5_still_idle", 32'(outs()), 32'd0);

    // Asynchronous reset in the middle of a SHIFT cycle.
    bus_m     = 16'd3;
    bus_q     = 16'h0001;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cyc = 0;
    while (!bus.sftA && (cyc < 50)) begin
      tick();
      cyc++;
    end
    chk("t1_reached_shift", 32'(bus.sftA), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_reset_outs", 32'(outs()), 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    n_done = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (bus.done || bus.busy) n_done++;
    end
    chk("t1_no_activity", 32'(n_done), 32'd0);
    run_op("t1_recover", 16'd3, 16'h0001, 37, 2, 32'h0000_0003);

`ifdef BOOTH_CTRL_ABORT_EN
    // Abort on the fifth EVAL cycle (busy with no strobes).
    bus_m     = 16'd7;
    bus_q     = 16'h5555;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cyc    = 0;
    n_done = 0;
    for (int i = 0; i < 100; i++) begin
      if (outs() == 11'b000_0000_0010) n_done++;
      if (n_done == 5) break;
      tick();
    end
    chk("t6_found_eval5", 32'(n_done), 32'd5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t6_busy_after_abort", 32'(bus.busy), 32'd0);
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) n_done++;
      tick();
    end
    chk("t6_no_done", 32'(n_done), 32'd0);
    run_op("t6_restart", 16'd3, 16'h0001, 37, 2, 32'h0000_0003);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
